// File: rtl/serial_subtractor32.sv
// serial_subtractor32
//   Multi-cycle two's-complement subtractor computing diff = a - b - bin.
//   One SLICE-bit slice is processed per clock, LSB slice first, through a
//   single shared slice subtractor with a registered borrow. Latency is
//   N = WIDTH/SLICE cycles from the accepted start to the done pulse.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - synchronous reset, active-low
//   start  - request, sampled only while idle
//   a, b   - minuend / subtrahend, captured on an accepted start
//   bin    - borrow in, captured on an accepted start
//   busy   - high while slices are being computed
//   done   - one-cycle pulse, results valid
//   diff   - a - b - bin modulo 2^WIDTH
//   bout   - unsigned borrow out of the MSB (a < b + bin)
//   of     - signed overflow of the subtraction
module serial_subtractor32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             of
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              borrow;
  logic [SLICE-1:0]  a_slice;
  logic [SLICE-1:0]  b_slice;
  logic [SLICE:0]    slice_res;
  logic              last;

  // Shared slice subtractor. Working one bit wider than the slice makes the
  // extra MSB the borrow out: it is set exactly when the zero-extended
  // difference went negative.
  always_comb begin
    a_slice   = a_reg[idx*SLICE +: SLICE];
    b_slice   = b_reg[idx*SLICE +: SLICE];
    slice_res = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE{1'b0}}, borrow};
    last      = (idx == LAST_IDX);
  end

  // Next-state logic: a start only matters in IDLE; RUN ends after the
  // last slice, so a start coinciding with done is taken immediately.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign busy = (state == RUN);

  // Datapath. Operands are frozen at acceptance so later input changes are
  // harmless. Results are cleared on acceptance and then filled slice by
  // slice; the overflow flag uses the freshly computed top slice because
  // diff itself is not updated until this same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      borrow <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      of     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bin;
            idx    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            of     <= 1'b0;
          end
        end
        RUN: begin
          diff[idx*SLICE +: SLICE] <= slice_res[SLICE-1:0];
          borrow                   <= slice_res[SLICE];
          idx                      <= idx + 1'b1;
          if (last) begin
            idx  <= '0;
            bout <= slice_res[SLICE];
            of   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                    (slice_res[SLICE-1] != a_reg[WIDTH-1]);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor32.sv
// tb_serial_subtractor32
//   Directed-vector bench for serial_subtractor32 (WIDTH=32, SLICE=8).
//   Inputs change on the falling edge, outputs are sampled on the falling
//   edge, so the DUT always sees stable inputs at the rising edge.
module tb_serial_subtractor32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bout;
  logic        of;

  int total;
  int bad;

  serial_subtractor32 #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .of    (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single rising edge. Returns at the falling
  // edge right after the accepting edge, with start already dropped.
  task automatic start_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic vbin);
    @(negedge clk);
    a     = va;
    b     = vb;
    bin   = vbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Step falling edges until done, bounded so a stuck DUT cannot hang the
  // run. cycles is the number of edges after acceptance; busy_cnt counts
  // sampled cycles with busy high before done.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd2;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    total++; if (diff !== 32'h0) begin bad++; $display("[TB] FAIL reset_diff: got %h expected 00000000", diff); end
    total++; if (bout !== 1'b0)  begin bad++; $display("[TB] FAIL reset_bout: got %b expected 0", bout); end
    total++; if (of !== 1'b0)    begin bad++; $display("[TB] FAIL reset_of: got %b expected 0", of); end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    int bcnt;
    start_op(32'd100, 32'd1, 1'b0);
    wait_done(cyc, bcnt);
    total++; if (cyc !== 4)       begin bad++; $display("[TB] FAIL basic_latency: got %0d expected 4", cyc); end
    total++; if (bcnt !== 4)      begin bad++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 4", bcnt); end
    total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy); end
    total++; if (diff !== 32'd99) begin bad++; $display("[TB] FAIL basic_diff: got %h expected 00000063", diff); end
    total++; if (bout !== 1'b0)   begin bad++; $display("[TB] FAIL basic_bout: got %b expected 0", bout); end
    total++; if (of !== 1'b0)     begin bad++; $display("[TB] FAIL basic_of: got %b expected 0", of); end
    @(negedge clk);
    total++; if (done !== 1'b0)   begin bad++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    @(negedge clk);
    total++; if (diff !== 32'd99) begin bad++; $display("[TB] FAIL basic_hold: got %h expected 00000063", diff); end
  endtask

  task automatic test_underflow();
    int cyc;
    int bcnt;
    start_op(32'd0, 32'd1, 1'b0);
    wait_done(cyc, bcnt);
    total++; if (diff !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL underflow_diff: got %h expected ffffffff", diff); end
    total++; if (bout !== 1'b1)         begin bad++; $display("[TB] FAIL underflow_bout: got %b expected 1", bout); end
    total++; if (of !== 1'b0)           begin bad++; $display("[TB] FAIL underflow_of: got %b expected 0", of); end
  endtask

  task automatic test_overflow();
    int cyc;
    int bcnt;
    start_op(32'h80000000, 32'd1, 1'b0);
    wait_done(cyc, bcnt);
    total++; if (diff !== 32'h7FFFFFFF) begin bad++; $display("[TB] FAIL ovf_neg_diff: got %h expected 7fffffff", diff); end
    total++; if (of !== 1'b1)           begin bad++; $display("[TB] FAIL ovf_neg_of: got %b expected 1", of); end
    total++; if (bout !== 1'b0)         begin bad++; $display("[TB] FAIL ovf_neg_bout: got %b expected 0", bout); end
    start_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done(cyc, bcnt);
    total++; if (diff !== 32'h80000000) begin bad++; $display("[TB] FAIL ovf_pos_diff: got %h expected 80000000", diff); end
    total++; if (of !== 1'b1)           begin bad++; $display("[TB] FAIL ovf_pos_of: got %b expected 1", of); end
    total++; if (bout !== 1'b1)         begin bad++; $display("[TB] FAIL ovf_pos_bout: got %b expected 1", bout); end
  endtask

  task automatic test_borrow_in();
    int cyc;
    int bcnt;
    start_op(32'd5, 32'd5, 1'b1);
    wait_done(cyc, bcnt);
    total++; if (diff !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL bin_equal_diff: got %h expected ffffffff", diff); end
    total++; if (bout !== 1'b1)         begin bad++; $display("[TB] FAIL bin_equal_bout: got %b expected 1", bout); end
    total++; if (of !== 1'b0)           begin bad++; $display("[TB] FAIL bin_equal_of: got %b expected 0", of); end
    start_op(32'h00000100, 32'd0, 1'b1);
    wait_done(cyc, bcnt);
    total++; if (diff !== 32'h000000FF) begin bad++; $display("[TB] FAIL bin_ripple_diff: got %h expected 000000ff", diff); end
    total++; if (bout !== 1'b0)         begin bad++; $display("[TB] FAIL bin_ripple_bout: got %b expected 0", bout); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va  [3];
    logic [31:0] vb  [3];
    logic        vbi [3];
    logic [31:0] ed  [3];
    logic        eb  [3];
    int cyc;
    int bcnt;
    va[0] = 32'd1000;      vb[0] = 32'd1;         vbi[0] = 1'b0; ed[0] = 32'd999;       eb[0] = 1'b0;
    va[1] = 32'h12345678;  vb[1] = 32'h11111111;  vbi[1] = 1'b0; ed[1] = 32'h01234567;  eb[1] = 1'b0;
    va[2] = 32'hFFFFFFFF;  vb[2] = 32'hFFFFFFFF;  vbi[2] = 1'b1; ed[2] = 32'hFFFFFFFF;  eb[2] = 1'b1;
    @(negedge clk);
    a     = va[0];
    b     = vb[0];
    bin   = vbi[0];
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_done(cyc, bcnt);
      total++; if (cyc !== 4)     begin bad++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 4", i, cyc); end
      total++; if (diff !== ed[i]) begin bad++; $display("[TB] FAIL b2b_diff[%0d]: got %h expected %h", i, diff, ed[i]); end
      total++; if (bout !== eb[i]) begin bad++; $display("[TB] FAIL b2b_bout[%0d]: got %b expected %b", i, bout, eb[i]); end
      if (i < 2) begin
        a   = va[i+1];
        b   = vb[i+1];
        bin = vbi[i+1];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_ignore_inputs();
    int cyc;
    int bcnt;
    start_op(32'd50, 32'd20, 1'b0);
    a     = 32'd999;
    b     = 32'd1;
    bin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    total++; if (cyc !== 3)       begin bad++; $display("[TB] FAIL ignore_latency: got %0d expected 3", cyc); end
    total++; if (diff !== 32'd30) begin bad++; $display("[TB] FAIL ignore_diff: got %h expected 0000001e", diff); end
    total++; if (bout !== 1'b0)   begin bad++; $display("[TB] FAIL ignore_bout: got %b expected 0", bout); end
    @(negedge clk);
    total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL ignore_no_restart: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int bcnt;
    int seen;
    start_op(32'd1000, 32'd1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    total++; if (diff !== 32'h0) begin bad++; $display("[TB] FAIL midrst_diff: got %h expected 00000000", diff); end
    total++; if (bout !== 1'b0)  begin bad++; $display("[TB] FAIL midrst_bout: got %b expected 0", bout); end
    total++; if (of !== 1'b0)    begin bad++; $display("[TB] FAIL midrst_of: got %b expected 0", of); end
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", seen); end
    start_op(32'd10, 32'd3, 1'b0);
    wait_done(cyc, bcnt);
    total++; if (cyc !== 4)      begin bad++; $display("[TB] FAIL midrst_restart_latency: got %0d expected 4", cyc); end
    total++; if (diff !== 32'd7) begin bad++; $display("[TB] FAIL midrst_restart_diff: got %h expected 00000007", diff); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_borrow_in();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
